// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Contents: access-size, fault-code and FSM-state enums, and size-to-lane helpers.
package lsu_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE   = 2'b00,
        MEM_HALF   = 2'b01,
        MEM_WORD   = 2'b10,
        MEM_DOUBLE = 2'b11
    } mem_size_t;

    typedef enum logic [1:0] {
        FLT_NONE     = 2'b00,
        FLT_MISALIGN = 2'b01,
        FLT_TIMEOUT  = 2'b10,
        FLT_SIZE     = 2'b11
    } lsu_fault_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT_R  = 3'd2,
        ST_RESP    = 3'd3,
        ST_ISSUE2  = 3'd4,
        ST_WAIT_R2 = 3'd5
    } lsu_state_t;

    // Number of bytes touched by an access of the given size.
    function automatic logic [3:0] size_bytes(input mem_size_t s);
        return 4'd1 << s;
    endfunction

    // LSB-aligned byte-lane mask for an access of the given size.
    function automatic logic [7:0] size_mask(input mem_size_t s);
        case (s)
            MEM_BYTE: return 8'h01;
            MEM_HALF: return 8'h03;
            MEM_WORD: return 8'h0F;
            default:  return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/load_align_extend.sv
// Load data aligner: shifts the addressed lanes down to bit 0, keeps the
// access-size field and sign- or zero-extends it to XLEN.
// Ports: data (raw memory word), offset (byte offset), size, is_signed -> result.
module load_align_extend
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0]           data,
    input  logic [$clog2(XLEN/8)-1:0] offset,
    input  mem_size_t                 size,
    input  logic                      is_signed,
    output logic [XLEN-1:0]           result
);

    localparam int unsigned KW = $clog2(XLEN);

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] up;
    logic [KW-1:0]   k;

    // Push the field to the top, then shift back down arithmetically or logically.
    always_comb begin
        shifted = data >> {offset, 3'b000};
        case (size)
            MEM_BYTE: k = KW'(XLEN - 8);
            MEM_HALF: k = KW'(XLEN - 16);
            MEM_WORD: k = KW'(XLEN - 32);
            default:  k = '0;
        endcase
        up     = shifted << k;
        result = is_signed ? XLEN'($signed(up) >>> k) : (up >> k);
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: sequences one core request onto a handshaked data-memory
// port, generating byte enables, lane-shifting store data and aligning/extending
// load data. Reports misaligned, timeout and illegal-size faults.
// Ports: core side req_* in / req_ready, resp_* out; memory side mem_* out,
// mem_ready / mem_rvalid / mem_rdata in. Synchronous active-low reset_n.
// Option: define LSU_MISALIGN_SPLIT_EN to issue misaligned accesses (two beats
// when they cross a word); otherwise every misaligned access faults.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [XLEN-1:0]       req_addr,
    input  logic [XLEN-1:0]       req_wdata,
    output logic                  resp_valid,
    output logic [XLEN-1:0]       resp_rdata,
    output logic [1:0]            resp_fault,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [XLEN/8-1:0]     mem_be,
    output logic [XLEN-1:0]       mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [XLEN-1:0]       mem_rdata
);

    localparam int unsigned NB  = XLEN / 8;
    localparam int unsigned NB2 = 2 * NB;
    localparam int unsigned L   = $clog2(NB);
    localparam int unsigned CW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    lsu_state_t            state, state_d;
    logic                  we_q, signed_q;
    mem_size_t             size_q;
    logic [L-1:0]          off_q;
    logic [ADDR_WIDTH-1:0] word_q;
    logic [XLEN-1:0]       wdata_q;
    logic [CW-1:0]         cnt_q;

    logic                  req_ready_d, mem_valid_d, mem_we_d, resp_valid_d;
    logic [ADDR_WIDTH-1:0] mem_addr_d;
    logic [NB-1:0]         mem_be_d;
    logic [XLEN-1:0]       mem_wdata_d, resp_rdata_d;
    lsu_fault_t            resp_fault_d;

    // Request decode
    mem_size_t    req_size_c;
    logic [L-1:0] req_off_c;
    logic         accept_c, size_bad_c, misalign_c, timeout_c, cross_c;
    logic         unused_addr_bits;

    assign req_size_c       = mem_size_t'(req_size);
    assign req_off_c        = req_addr[L-1:0];
    assign accept_c         = req_valid & req_ready;
    assign size_bad_c       = (XLEN == 32) && (req_size == 2'b11);
    assign misalign_c       = |(req_off_c & L'(size_bytes(req_size_c) - 4'd1));
    assign timeout_c        = (cnt_q == '0);
    assign unused_addr_bits = ^req_addr[XLEN-1:ADDR_WIDTH+L];

    // Lane placement over a double-width window: low half is beat 1, high half beat 2.
    mem_size_t       src_size;
    logic [L-1:0]    src_off;
    logic [XLEN-1:0] src_wdata;
    logic [NB2-1:0]  be_2x;
    logic [2*XLEN-1:0] wd_2x;

    assign src_size  = (state == ST_IDLE) ? req_size_c : size_q;
    assign src_off   = (state == ST_IDLE) ? req_off_c  : off_q;
    assign src_wdata = (state == ST_IDLE) ? req_wdata  : wdata_q;
    assign be_2x     = NB2'(size_mask(src_size)) << src_off;
    assign wd_2x     = (2 * XLEN)'(src_wdata) << {src_off, 3'b000};
    assign cross_c   = ((L + 2)'(src_off) + (L + 2)'(size_bytes(src_size))) > (L + 2)'(NB);

    // Load data path; a split load merges both beats and aligns from offset 0.
    logic [XLEN-1:0] align_in, align_out;
    logic [L-1:0]    align_off;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic [XLEN-1:0] lo_q;
    logic [L+3:0]    hi_sh;
    assign hi_sh     = {(L + 1)'(NB) - {1'b0, off_q}, 3'b000};
    assign align_in  = (state == ST_WAIT_R2) ? (lo_q | (mem_rdata << hi_sh)) : mem_rdata;
    assign align_off = (state == ST_WAIT_R2) ? '0 : off_q;
`else
    assign align_in  = mem_rdata;
    assign align_off = off_q;
`endif

    load_align_extend #(.XLEN(XLEN)) u_align (
        .data      (align_in),
        .offset    (align_off),
        .size      (size_q),
        .is_signed (signed_q),
        .result    (align_out)
    );

    // State register; outputs are registered from their next values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b0;
            mem_valid  <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_fault <= 2'b00;
        end else begin
            state      <= state_d;
            req_ready  <= req_ready_d;
            mem_valid  <= mem_valid_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_be     <= mem_be_d;
            mem_wdata  <= mem_wdata_d;
            resp_valid <= resp_valid_d;
            resp_rdata <= resp_rdata_d;
            resp_fault <= resp_fault_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: begin
                if (accept_c) begin
                    if (size_bad_c)                  state_d = ST_RESP;
                    else if (!SPLIT_EN && misalign_c) state_d = ST_RESP;
                    else                             state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_ready) begin
                    if (SPLIT_EN && cross_c && we_q) state_d = ST_ISSUE2;
                    else                             state_d = we_q ? ST_RESP : ST_WAIT_R;
                end
            end
            ST_WAIT_R: begin
                if (mem_rvalid)     state_d = (SPLIT_EN && cross_c) ? ST_ISSUE2 : ST_RESP;
                else if (timeout_c) state_d = ST_RESP;
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            // First ISSUE2 cycle is a bubble while the beat-2 fields register.
            ST_ISSUE2: begin
                if (mem_valid && mem_ready) state_d = we_q ? ST_RESP : ST_WAIT_R2;
            end
            ST_WAIT_R2: begin
                if (mem_rvalid || timeout_c) state_d = ST_RESP;
            end
`endif
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output next-value logic
    always_comb begin
        req_ready_d  = (state_d == ST_IDLE);
        mem_valid_d  = (state_d == ST_ISSUE) || (state_d == ST_ISSUE2 && state == ST_ISSUE2);
        mem_we_d     = mem_we;
        mem_addr_d   = mem_addr;
        mem_be_d     = mem_be;
        mem_wdata_d  = mem_wdata;
        resp_valid_d = (state_d == ST_RESP);
        resp_rdata_d = '0;
        resp_fault_d = FLT_NONE;

        if (state == ST_IDLE && state_d == ST_ISSUE) begin
            mem_we_d    = req_we;
            mem_addr_d  = req_addr[ADDR_WIDTH+L-1:L];
            mem_be_d    = be_2x[NB-1:0];
            mem_wdata_d = wd_2x[XLEN-1:0];
        end
        if (state_d == ST_ISSUE2 && state != ST_ISSUE2) begin
            mem_addr_d  = word_q + ADDR_WIDTH'(1);
            mem_be_d    = be_2x[NB2-1:NB];
            mem_wdata_d = wd_2x[2*XLEN-1:XLEN];
        end
        if (state_d != ST_ISSUE && state_d != ST_ISSUE2) begin
            mem_we_d    = 1'b0;
            mem_addr_d  = '0;
            mem_be_d    = '0;
            mem_wdata_d = '0;
        end

        if (state_d == ST_RESP) begin
            if (state == ST_IDLE) begin
                resp_fault_d = size_bad_c ? FLT_SIZE : FLT_MISALIGN;
            end else if (state == ST_WAIT_R || state == ST_WAIT_R2) begin
                if (mem_rvalid) resp_rdata_d = align_out;
                else            resp_fault_d = FLT_TIMEOUT;
            end
        end
    end

    // Request capture, read timeout counter and beat-1 load data
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            size_q   <= MEM_BYTE;
            off_q    <= '0;
            word_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            lo_q     <= '0;
`endif
        end else begin
            if (accept_c) begin
                we_q     <= req_we;
                signed_q <= req_signed;
                size_q   <= req_size_c;
                off_q    <= req_off_c;
                word_q   <= req_addr[ADDR_WIDTH+L-1:L];
                wdata_q  <= req_wdata;
            end
            if ((state_d == ST_WAIT_R || state_d == ST_WAIT_R2) && state_d != state)
                cnt_q <= CW'(TIMEOUT_CYCLES - 1);
            else if ((state == ST_WAIT_R || state == ST_WAIT_R2) && !timeout_c)
                cnt_q <= cnt_q - CW'(1);
`ifdef LSU_MISALIGN_SPLIT_EN
            if (state == ST_WAIT_R && mem_rvalid)
                lo_q <= mem_rdata >> {off_q, 3'b000};
`endif
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (XLEN=32, ADDR_WIDTH=10, TIMEOUT_CYCLES=4).
// Inputs are driven and outputs checked on the falling clock edge.
module tb_load_store_unit;

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 10;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            req_valid, req_ready, req_we, req_signed;
    logic [1:0]      req_size;
    logic [XLEN-1:0] req_addr, req_wdata;
    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic [1:0]      resp_fault;
    logic            mem_valid, mem_ready, mem_we, mem_rvalid;
    logic [AW-1:0]   mem_addr;
    logic [3:0]      mem_be;
    logic [XLEN-1:0] mem_wdata, mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    load_store_unit #(.XLEN(XLEN), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Present a request for one cycle; returns in cycle 1 after the accept edge.
    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        check("ready_at_accept", req_ready, 1);
        tick();
        req_valid = 1'b0;
    endtask

    // Zero-wait load: mem_ready in cycle 1, mem_rvalid in cycle 2, response in cycle 3.
    task automatic zw_load(input string tag, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] rdata,
                           input logic [3:0] be, input logic [31:0] exp);
        issue(1'b0, size, sgn, addr, 32'h0);
        check({tag, "_mvalid"}, mem_valid, 1);
        check({tag, "_be"}, mem_be, be);
        check({tag, "_addr"}, mem_addr, addr >> 2);
        check({tag, "_we"}, mem_we, 0);
        mem_ready = 1'b1;
        tick();
        mem_ready  = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        check({tag, "_early_resp"}, resp_valid, 0);
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        check({tag, "_resp"}, resp_valid, 1);
        check({tag, "_rdata"}, resp_rdata, exp);
        check({tag, "_fault"}, resp_fault, 0);
        tick();
        check({tag, "_ready_back"}, req_ready, 1);
    endtask

    initial begin
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;

        // Reset state
        tick();
        tick();
        check("rst_req_ready", req_ready, 0);
        check("rst_mem_valid", mem_valid, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_fault", resp_fault, 0);
        check("rst_mem_be", mem_be, 0);
        reset_n = 1'b1;
        tick();
        check("rst_release_ready", req_ready, 1);

        // SW 0x8 <- 0xDEADBEEF, zero-wait
        issue(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF);
        check("sw_mvalid", mem_valid, 1);
        check("sw_we", mem_we, 1);
        check("sw_addr", mem_addr, 2);
        check("sw_be", mem_be, 4'hF);
        check("sw_wdata", mem_wdata, 32'hDEADBEEF);
        check("sw_busy", req_ready, 0);
        check("sw_no_resp_c1", resp_valid, 0);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("sw_resp_c2", resp_valid, 1);
        check("sw_fault", resp_fault, 0);
        check("sw_rdata", resp_rdata, 0);
        check("sw_mvalid_drop", mem_valid, 0);
        tick();
        check("sw_resp_pulse", resp_valid, 0);
        check("sw_ready_c3", req_ready, 1);

        // Loads with lane selection and extension
        zw_load("lb",  2'b00, 1'b1, 32'h5,  32'h0000_8000, 4'b0010, 32'hFFFF_FF80);
        zw_load("lbu", 2'b00, 1'b0, 32'h5,  32'h0000_8000, 4'b0010, 32'h0000_0080);
        zw_load("lh",  2'b01, 1'b1, 32'h6,  32'h8001_1234, 4'b1100, 32'hFFFF_8001);
        zw_load("lhu", 2'b01, 1'b0, 32'h6,  32'h8001_1234, 4'b1100, 32'h0000_8001);
        zw_load("lw",  2'b10, 1'b1, 32'h10, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

        // SB 0x7 with two memory wait states and a stray mem_rvalid during ISSUE
        issue(1'b1, 2'b00, 1'b0, 32'h7, 32'h0000_00A5);
        check("sb_be", mem_be, 4'b1000);
        check("sb_wdata", mem_wdata, 32'hA500_0000);
        check("sb_addr", mem_addr, 1);
        mem_rvalid = 1'b1;
        tick();
        check("sb_hold_valid", mem_valid, 1);
        check("sb_hold_be", mem_be, 4'b1000);
        check("sb_hold_noresp", resp_valid, 0);
        tick();
        check("sb_hold_wdata", mem_wdata, 32'hA500_0000);
        mem_rvalid = 1'b0;
        mem_ready  = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("sb_resp", resp_valid, 1);
        check("sb_fault", resp_fault, 0);
        tick();

        // Misaligned SH 0x3: immediate fault, no memory access
        issue(1'b1, 2'b01, 1'b0, 32'h3, 32'h0000_1234);
        check("mis_resp_c1", resp_valid, 1);
        check("mis_fault", resp_fault, 2'b01);
        check("mis_no_mem", mem_valid, 0);
        tick();
        check("mis_no_mem_c2", mem_valid, 0);
        check("mis_ready_c2", req_ready, 1);

        // Misaligned LW 0x2
        issue(1'b0, 2'b10, 1'b0, 32'h2, 32'h0);
        check("mislw_fault", resp_fault, 2'b01);
        check("mislw_no_mem", mem_valid, 0);
        tick();

        // Illegal size
        issue(1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
        check("size_resp_c1", resp_valid, 1);
        check("size_fault", resp_fault, 2'b11);
        check("size_no_mem", mem_valid, 0);
        tick();
        check("size_no_mem_c2", mem_valid, 0);

        // Timeout: mem_rvalid withheld for 4 WAIT_R cycles
        issue(1'b0, 2'b10, 1'b0, 32'hC, 32'h0);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("to_waiting", resp_valid, 0);
            tick();
        end
        check("to_resp", resp_valid, 1);
        check("to_fault", resp_fault, 2'b10);
        check("to_rdata", resp_rdata, 0);
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        check("to_ready", req_ready, 1);
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        check("stray_rvalid_noresp", resp_valid, 0);
        check("stray_rvalid_nomem", mem_valid, 0);

        // Data arriving in the last allowed WAIT_R cycle still completes
        issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("late_waiting", resp_valid, 0);
            tick();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        check("late_resp", resp_valid, 1);
        check("late_fault", resp_fault, 0);
        check("late_rdata", resp_rdata, 32'h1234_5678);
        tick();

        // Reset during ISSUE drops mem_valid at that edge
        issue(1'b1, 2'b10, 1'b0, 32'h0, 32'h1111_2222);
        check("rsti_mvalid_before", mem_valid, 1);
        reset_n = 1'b0;
        tick();
        check("rsti_mvalid", mem_valid, 0);
        check("rsti_resp", resp_valid, 0);
        reset_n = 1'b1;
        tick();
        check("rsti_ready", req_ready, 1);

        // Reset during WAIT_R aborts the load
        issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        reset_n   = 1'b0;
        tick();
        check("rstw_mvalid", mem_valid, 0);
        check("rstw_resp", resp_valid, 0);
        check("rstw_ready", req_ready, 0);
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        check("rstw_resp2", resp_valid, 0);
        reset_n = 1'b1;
        tick();
        check("rstw_ready_back", req_ready, 1);
        check("rstw_resp3", resp_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
